// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU and its issue stage.
// func3 encodings are common to both sides of the EX boundary.
package alu_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic {
    RUN,
    TRAP
  } issue_state_t;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  f3;
    logic        subsra;
    logic [4:0]  rd;
  } ex_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction valid/ready handshake into the issue stage.
// master drives the instruction word, slave answers with ready.
interface alu_issue_stage_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );
endinterface

// File: rtl/alu.sv
// Combinational RV32I integer ALU driven by the issue stage.
// subsra selects SUB for ADD and arithmetic shift for SR.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic [2:0]  func3,
  input  logic        subsra,
  output logic [31:0] result
);

  logic [4:0] sh;
  assign sh = operand2[4:0];

  always_comb begin
    result = '0;
    unique case (func3)
      F3_ADD:  result = subsra ? operand1 - operand2
                               : operand1 + operand2;
      F3_SLL:  result = operand1 << sh;
      F3_SLT:  result = {31'd0, $signed(operand1) < $signed(operand2)};
      F3_SLTU: result = {31'd0, operand1 < operand2};
      F3_XOR:  result = operand1 ^ operand2;
      F3_SR:   result = subsra ? 32'($signed(operand1) >>> sh)
                               : operand1 >> sh;
      F3_OR:   result = operand1 | operand2;
      F3_AND:  result = operand1 & operand2;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/regfile.sv
// 32x32 register file: two async read ports, debug read, one write.
// x0 is never written, so it reads zero after reset.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [0:31];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rd1      = regs[ra1];
  assign rd2      = regs[ra2];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage for RV32I OP and OP-IMM feeding the ALU,
// with one EX->decode forwarding path and an illegal-instr trap.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  alu_issue_stage_if.slave   issue,
  output logic [31:0]        operand1,
  output logic [31:0]        operand2,
  output logic [2:0]         func3,
  output logic               subsra,
  input  logic [31:0]        alu_result,
  output logic               wb_valid,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_data,
  output logic               illegal,
  input  logic               trap_clear,
  input  logic [4:0]         dbg_addr,
  output logic [31:0]        dbg_data
);

  issue_state_t state, state_nx;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;

  assign opc = issue.instr[6:0];
  assign rd  = issue.instr[11:7];
  assign f3  = issue.instr[14:12];
  assign rs1 = issue.instr[19:15];
  assign rs2 = issue.instr[24:20];
  assign f7  = issue.instr[31:25];
  assign imm = {{20{issue.instr[31]}}, issue.instr[31:20]};

  logic legal, is_op, sub_d;

  always_comb begin
    legal = 1'b0;
    is_op = 1'b0;
    sub_d = 1'b0;
    unique case (1'b1)
      opc == OPC_OP: begin
        is_op = 1'b1;
        sub_d = issue.instr[30];
        legal = (f7 == F7_BASE) ||
                (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
      end
      opc == OPC_OPIMM: begin
        legal = 1'b1;
        if (f3 == F3_SLL) begin
          legal = (f7 == F7_BASE);
        end else if (f3 == F3_SR) begin
          legal = (f7 == F7_BASE) || (f7 == F7_ALT);
          sub_d = issue.instr[30];
        end
      end
      default: ;
    endcase
  end

  logic accept, issue_ok;
  assign issue.instr_ready = !rst && state == RUN;
  assign accept   = issue.instr_valid && issue.instr_ready;
  assign issue_ok = accept && legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:  if (accept && !legal) state_nx = TRAP;
      TRAP: if (trap_clear)       state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  assign illegal = (state == TRAP);

  logic        e_valid;
  logic [4:0]  e_rd;
  logic [31:0] rf1, rf2;

  regfile u_rf (
    .clk      (clk),
    .rst      (rst),
    .ra1      (rs1),
    .ra2      (rs2),
    .rd1      (rf1),
    .rd2      (rf2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (e_valid),
    .waddr    (e_rd),
    .wdata    (alu_result)
  );

  // rs2 forwarding only matters when rs2 is really a source (OP)
  logic fwd1, fwd2;
  assign fwd1 = e_valid && e_rd != 5'd0 && rs1 == e_rd;
  assign fwd2 = e_valid && e_rd != 5'd0 && rs2 == e_rd && is_op;

  ex_t ex_d;
  always_comb begin
    ex_d.op1    = fwd1 ? alu_result : rf1;
    ex_d.op2    = is_op ? (fwd2 ? alu_result : rf2) : imm;
    ex_d.f3     = f3;
    ex_d.subsra = sub_d;
    ex_d.rd     = rd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid  <= 1'b0;
      e_rd     <= '0;
      operand1 <= '0;
      operand2 <= '0;
      func3    <= '0;
      subsra   <= 1'b0;
    end else begin
      e_valid <= issue_ok;
      if (issue_ok) begin
        e_rd     <= ex_d.rd;
        operand1 <= ex_d.op1;
        operand2 <= ex_d.op2;
        func3    <= ex_d.f3;
        subsra   <= ex_d.subsra;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= e_valid;
      if (e_valid) begin
        wb_rd   <= e_rd;
        wb_data <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage with the real alu closing the loop.
// Write-backs are checked against a queue of expected {rd,data}.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] operand1, operand2, alu_result, wb_data, dbg_data;
  logic [2:0]  func3;
  logic        subsra, wb_valid, illegal;
  logic        trap_clear = 1'b0;
  logic [4:0]  wb_rd;
  logic [4:0]  dbg_addr = 5'd0;

  int vectors = 0;
  int miscompares = 0;
  logic [36:0] q[$];

  alu_issue_stage_if ifc ();

  alu_issue_stage dut (
    .clk        (clk),
    .rst        (rst),
    .issue      (ifc),
    .operand1   (operand1),
    .operand2   (operand2),
    .func3      (func3),
    .subsra     (subsra),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .illegal    (illegal),
    .trap_clear (trap_clear),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  alu u_alu (
    .operand1 (operand1),
    .operand2 (operand2),
    .func3    (func3),
    .subsra   (subsra),
    .result   (alu_result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [11:0] im,
      input logic [4:0] s1, input logic [2:0] f, input logic [4:0] d);
    return {im, s1, f, d, OPC_OPIMM};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7,
      input logic [4:0] s2, input logic [4:0] s1,
      input logic [2:0] f, input logic [4:0] d);
    return {f7, s2, s1, f, d, OPC_OP};
  endfunction

  always @(negedge clk) begin
    if (!rst && wb_valid === 1'b1) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL wb_unexpected got rd=%0d data=%h required none",
                 wb_rd, wb_data);
      end else begin
        logic [36:0] e;
        e = q.pop_front();
        if ({wb_rd, wb_data} !== e) begin
          miscompares++;
          $display("FAIL wb got rd=%0d data=%h required rd=%0d data=%h",
                   wb_rd, wb_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic send(input logic [31:0] w);
    ifc.instr_valid = 1'b1;
    ifc.instr = w;
    @(negedge clk);
    ifc.instr_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending required 0", q.size());
      q.delete();
    end
  endtask

  task automatic chk_dbg(input logic [4:0] a, input logic [31:0] e);
    dbg_addr = a;
    #1;
    vectors++;
    if (dbg_data !== e) begin
      miscompares++;
      $display("FAIL dbg_x%0d got %h required %h", a, dbg_data, e);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    vectors++;
    if ({operand1, operand2, func3, subsra, wb_valid, wb_rd, wb_data,
         illegal, ifc.instr_ready} !== '0) begin
      miscompares++;
      $display("FAIL %s got op1=%h op2=%h f3=%0d sub=%b wbv=%b rd=%0d wd=%h ill=%b rdy=%b required all 0",
               tag, operand1, operand2, func3, subsra, wb_valid, wb_rd,
               wb_data, illegal, ifc.instr_ready);
    end
  endtask

  task automatic chk_ready(input string tag, input logic ill,
                           input logic rdy);
    vectors++;
    if (illegal !== ill || ifc.instr_ready !== rdy) begin
      miscompares++;
      $display("FAIL %s got illegal=%b ready=%b required %b %b",
               tag, illegal, ifc.instr_ready, ill, rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.instr_valid = 1'b0;
    ifc.instr = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_zero_outputs("reset_outputs");
    chk_dbg(5'd1, 32'h0);
    rst = 1'b0;
    #1;
    chk_ready("reset_release", 1'b0, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_addi();
    q.push_back({5'd1, 32'h0000_07FF});
    send(enc_i(12'h7FF, 5'd0, F3_ADD, 5'd1));
    q.push_back({5'd2, 32'hFFFF_FFFF});
    send(enc_i(12'hFFF, 5'd0, F3_ADD, 5'd2));
    drain();
    chk_dbg(5'd2, 32'hFFFF_FFFF);
  endtask

  task automatic test_back_to_back();
    q.push_back({5'd3, 32'h0000_0FFE});
    send(enc_r(F7_BASE, 5'd1, 5'd1, F3_ADD, 5'd3));
    q.push_back({5'd4, 32'h0000_07FF});
    send(enc_r(F7_ALT, 5'd1, 5'd3, F3_ADD, 5'd4));
    #1;
    vectors++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd3) begin
      miscompares++;
      $display("FAIL b2b_first got v=%b rd=%0d required 1 3",
               wb_valid, wb_rd);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd4) begin
      miscompares++;
      $display("FAIL b2b_second got v=%b rd=%0d required 1 4",
               wb_valid, wb_rd);
    end
    drain();
    chk_dbg(5'd4, 32'h0000_07FF);
  endtask

  task automatic test_shift_x0();
    q.push_back({5'd5, 32'hFFFF_FFFF});
    send(enc_i({F7_ALT, 5'd4}, 5'd2, F3_SR, 5'd5));
    q.push_back({5'd6, 32'h0FFF_FFFF});
    send(enc_i({F7_BASE, 5'd4}, 5'd2, F3_SR, 5'd6));
    q.push_back({5'd0, 32'h0000_0FFE});
    send(enc_r(F7_BASE, 5'd1, 5'd1, F3_ADD, 5'd0));
    drain();
    chk_dbg(5'd6, 32'h0FFF_FFFF);
    chk_dbg(5'd0, 32'h0);
  endtask

  task automatic test_trap();
    send(enc_i({F7_ALT, 5'd1}, 5'd1, F3_SLL, 5'd8));
    #1;
    chk_ready("trap_enter", 1'b1, 1'b0);
    ifc.instr_valid = 1'b1;
    ifc.instr = enc_i(12'd1, 5'd0, F3_ADD, 5'd9);
    repeat (3) @(negedge clk);
    ifc.instr_valid = 1'b0;
    #1;
    chk_ready("trap_hold", 1'b1, 1'b0);
    chk_dbg(5'd9, 32'h0);
    chk_dbg(5'd8, 32'h0);
    trap_clear = 1'b1;
    @(negedge clk);
    trap_clear = 1'b0;
    #1;
    chk_ready("trap_clear", 1'b0, 1'b1);
    q.push_back({5'd9, 32'h0000_0003});
    send(enc_i(12'd3, 5'd0, F3_ADD, 5'd9));
    drain();
    chk_dbg(5'd9, 32'h0000_0003);
  endtask

  task automatic test_illegal_after_legal();
    q.push_back({5'd7, 32'h0000_0005});
    send(enc_i(12'd5, 5'd0, F3_ADD, 5'd7));
    send(32'h0000_0003);
    drain();
    chk_dbg(5'd7, 32'h0000_0005);
    chk_ready("ill_after_legal", 1'b1, 1'b0);
    trap_clear = 1'b1;
    @(negedge clk);
    trap_clear = 1'b0;
  endtask

  task automatic test_reset_mid();
    send(enc_i(12'd9, 5'd0, F3_ADD, 5'd10));
    rst = 1'b1;
    #1;
    chk_zero_outputs("reset_mid");
    chk_dbg(5'd1, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_ready("reset_mid_release", 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk_dbg(5'd10, 32'h0);
  endtask

  initial begin
    ifc.instr_valid = 1'b0;
    ifc.instr = '0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_shift_x0();
    test_trap();
    test_illegal_after_legal();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running required finished");
    $fatal(1);
  end

endmodule
